// File: rtl/msi_snoop_responder.sv
// Bus-side MSI snoop responder: per-line state/tag array, snoop FSM with write-back and response.
// Optional SNOOP_STATS_EN adds saturating hit/flush/error counters.
module msi_snoop_responder #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               snoop_valid,
  output logic               snoop_ready,
  input  logic [1:0]         snoop_op,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag,
  output logic               flush_valid,
  output logic [INDEX_W-1:0] flush_index,
  output logic [TAG_W-1:0]   flush_tag,
  input  logic               flush_ack,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_flushed,
  output logic               resp_err,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [TAG_W-1:0]   upd_tag,
  input  logic [1:0]         upd_state
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]        stat_hits,
  output logic [15:0]        stat_flushes,
  output logic [15:0]        stat_errs
`endif
);

  localparam int unsigned NUM_LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {LINE_I = 2'b00, LINE_M = 2'b01, LINE_S = 2'b10} line_e;
  typedef enum logic [1:0] {OP_INV = 2'b00, OP_WM = 2'b01, OP_RM = 2'b10, OP_ILL = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FLUSH, S_RESP} fsm_e;

  fsm_e               fsm_q, fsm_d;
  line_e              line_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic               active_q;
  op_e                op_q, op_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   ctag_q, ctag_d;
  line_e              nst_q, nst_d;
  logic               hit_q, hit_d, fl_q, fl_d, err_q, err_d;
  logic               line_we;
  line_e              line_wd;
  logic               lk_hit, snoop_fire, upd_fire;

  assign lk_hit      = (line_q[index_q] != LINE_I) && (tag_q[index_q] == ctag_q);
  // active_q keeps both ready outputs low until the first edge after reset release
  assign snoop_ready = active_q && (fsm_q == S_IDLE) && !(upd_valid && (upd_index == snoop_index));
  assign upd_ready   = active_q && !((fsm_q != S_IDLE) && (upd_index == index_q));
  assign snoop_fire  = snoop_valid && snoop_ready;
  assign upd_fire    = upd_valid && upd_ready;

  always_comb begin
    fsm_d   = fsm_q;
    op_d    = op_q;
    index_d = index_q;
    ctag_d  = ctag_q;
    nst_d   = nst_q;
    hit_d   = hit_q;
    fl_d    = fl_q;
    err_d   = err_q;
    line_we = 1'b0;
    line_wd = LINE_I;
    case (fsm_q)
      S_IDLE: begin
        if (snoop_fire) begin
          op_d    = op_e'(snoop_op);
          index_d = snoop_index;
          ctag_d  = snoop_tag;
          fsm_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lk_hit;
        fl_d  = 1'b0;
        err_d = (op_q == OP_ILL);
        fsm_d = S_RESP;
        if (lk_hit) begin
          case (op_q)
            OP_RM: begin
              if (line_q[index_q] == LINE_M) begin
                nst_d = LINE_S;
                fsm_d = S_FLUSH;
              end
            end
            OP_WM: begin
              if (line_q[index_q] == LINE_M) begin
                nst_d = LINE_I;
                fsm_d = S_FLUSH;
              end else begin
                line_we = 1'b1;
              end
            end
            OP_INV: begin
              line_we = 1'b1;
              err_d   = (line_q[index_q] == LINE_M);
            end
            default: ;
          endcase
        end
      end
      S_FLUSH: begin
        if (flush_ack) begin
          line_we = 1'b1;
          line_wd = nst_q;
          fl_d    = 1'b1;
          fsm_d   = S_RESP;
        end
      end
      S_RESP:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      active_q <= 1'b0;
      op_q     <= OP_INV;
      index_q  <= '0;
      ctag_q   <= '0;
      nst_q    <= LINE_I;
      hit_q    <= 1'b0;
      fl_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      active_q <= 1'b1;
      op_q     <= op_d;
      index_q  <= index_d;
      ctag_q   <= ctag_d;
      nst_q    <= nst_d;
      hit_q    <= hit_d;
      fl_q     <= fl_d;
      err_q    <= err_d;
    end
  end

  // Update and snoop writes never collide: upd_ready blocks the captured index while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        line_q[i] <= LINE_I;
        tag_q[i]  <= '0;
      end
    end else begin
      if (upd_fire) begin
        line_q[upd_index] <= (upd_state == 2'b11) ? LINE_I : line_e'(upd_state);
        tag_q[upd_index]  <= upd_tag;
      end
      if (line_we) begin
        line_q[index_q] <= line_wd;
      end
    end
  end

  assign flush_valid  = (fsm_q == S_FLUSH);
  assign flush_index  = flush_valid ? index_q : '0;
  assign flush_tag    = flush_valid ? ctag_q : '0;
  assign resp_valid   = (fsm_q == S_RESP);
  assign resp_hit     = resp_valid && hit_q;
  assign resp_flushed = resp_valid && fl_q;
  assign resp_err     = resp_valid && err_q;

`ifdef SNOOP_STATS_EN
  logic [15:0] hits_q, flushes_q, errs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q    <= '0;
      flushes_q <= '0;
      errs_q    <= '0;
    end else if (resp_valid) begin
      if (resp_hit && (hits_q != '1))        hits_q    <= hits_q + 16'd1;
      if (resp_flushed && (flushes_q != '1)) flushes_q <= flushes_q + 16'd1;
      if (resp_err && (errs_q != '1))        errs_q    <= errs_q + 16'd1;
    end
  end

  assign stat_hits    = hits_q;
  assign stat_flushes = flushes_q;
  assign stat_errs    = errs_q;
`endif

endmodule

// File: tb/tb_msi_snoop_responder.sv
// Directed bench for msi_snoop_responder: line state is observed only through snoop responses.
module tb_msi_snoop_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       snoop_valid, snoop_ready;
  logic [1:0] snoop_op;
  logic [3:0] snoop_index;
  logic [7:0] snoop_tag;
  logic       flush_valid, flush_ack;
  logic [3:0] flush_index;
  logic [7:0] flush_tag;
  logic       resp_valid, resp_hit, resp_flushed, resp_err;
  logic       upd_valid, upd_ready;
  logic [3:0] upd_index;
  logic [7:0] upd_tag;
  logic [1:0] upd_state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] INV = 2'b00, WM = 2'b01, RM = 2'b10, ILL = 2'b11;
  localparam logic [1:0] ST_I = 2'b00, ST_M = 2'b01, ST_S = 2'b10;

  always #5 clk = ~clk;

  msi_snoop_responder #(.INDEX_W(4), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_op(snoop_op),
    .snoop_index(snoop_index), .snoop_tag(snoop_tag),
    .flush_valid(flush_valid), .flush_index(flush_index), .flush_tag(flush_tag),
    .flush_ack(flush_ack),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_flushed(resp_flushed),
    .resp_err(resp_err),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_state(upd_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [3:0] idx, input logic [7:0] tag, input logic [1:0] st);
    @(negedge clk);
    upd_valid = 1'b1; upd_index = idx; upd_tag = tag; upd_state = st;
    #1 chk("upd_ready", {31'd0, upd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Entered with snoop_valid high and snoop_ready already seen high; the next edge is the handshake.
  task automatic snoop_wait(input string nm, input logic [3:0] idx, input logic [7:0] tag,
                            input int ack_at, input bit eh, input bit ef, input bit ee,
                            input int exp_lat);
    int lat = 1;
    int fc  = 0;
    bit got = 1'b0;
    @(posedge clk);
    @(negedge clk);
    snoop_valid = 1'b0;
    upd_valid   = 1'b0;
    upd_index   = idx;
    #1 chk({nm, ":upd_blocked"}, {31'd0, upd_ready}, 32'd0);
    while (!got && lat < 30) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (flush_valid) begin
          fc++;
          chk({nm, ":flush_index"}, {28'd0, flush_index}, {28'd0, idx});
          chk({nm, ":flush_tag"}, {24'd0, flush_tag}, {24'd0, tag});
          flush_ack = (fc == ack_at);
        end else begin
          flush_ack = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    flush_ack = 1'b0;
    chk({nm, ":resp_seen"}, {31'd0, got}, 32'd1);
    chk({nm, ":latency"}, lat, exp_lat);
    chk({nm, ":hit"}, {31'd0, resp_hit}, {31'd0, eh});
    chk({nm, ":flushed"}, {31'd0, resp_flushed}, {31'd0, ef});
    chk({nm, ":err"}, {31'd0, resp_err}, {31'd0, ee});
    chk({nm, ":flush_cycles"}, fc, ef ? ack_at : 0);
    @(negedge clk);
    chk({nm, ":resp_one_cycle"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic snoop(input string nm, input logic [1:0] op, input logic [3:0] idx,
                       input logic [7:0] tag, input int ack_at,
                       input bit eh, input bit ef, input bit ee, input int exp_lat);
    snoop_valid = 1'b1; snoop_op = op; snoop_index = idx; snoop_tag = tag;
    #1 chk({nm, ":snoop_ready"}, {31'd0, snoop_ready}, 32'd1);
    snoop_wait(nm, idx, tag, ack_at, eh, ef, ee, exp_lat);
  endtask

  initial begin
    rst_n = 1'b0;
    snoop_valid = 1'b0; snoop_op = 2'b00; snoop_index = '0; snoop_tag = '0;
    flush_ack = 1'b0;
    upd_valid = 1'b0; upd_index = '0; upd_tag = '0; upd_state = '0;
    snoop_valid = 1'b1;
    upd_valid   = 1'b1; upd_index = 4'd1;
    repeat (2) @(negedge clk);
    chk("rst:snoop_ready", {31'd0, snoop_ready}, 32'd0);
    chk("rst:upd_ready", {31'd0, upd_ready}, 32'd0);
    chk("rst:flush_valid", {31'd0, flush_valid}, 32'd0);
    chk("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    snoop_valid = 1'b0; upd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    snoop("rm3_miss", RM, 4'd3, 8'h12, 0, 0, 0, 0, 2);
    snoop("rm3_again", RM, 4'd3, 8'h12, 0, 0, 0, 0, 2);

    upd(4'd5, 8'hA0, ST_S);
    snoop("wm5_shared", WM, 4'd5, 8'hA0, 0, 1, 0, 0, 2);
    snoop("rm5_inval", RM, 4'd5, 8'hA0, 0, 0, 0, 0, 2);

    upd(4'd2, 8'h33, ST_M);
    snoop("rm2_mod", RM, 4'd2, 8'h33, 4, 1, 1, 0, 6);
    snoop("rm2_shared", RM, 4'd2, 8'h33, 0, 1, 0, 0, 2);

    upd(4'd7, 8'h44, ST_M);
    snoop("inv7_mod", INV, 4'd7, 8'h44, 0, 1, 0, 1, 2);
    snoop("rm7_inval", RM, 4'd7, 8'h44, 0, 0, 0, 0, 2);

    snoop("ill2_hit", ILL, 4'd2, 8'h33, 0, 1, 0, 1, 2);
    snoop("rm2_unchanged", RM, 4'd2, 8'h33, 0, 1, 0, 0, 2);
    snoop("ill3_miss", ILL, 4'd3, 8'h12, 0, 0, 0, 1, 2);

    upd(4'd8, 8'h66, ST_M);
    snoop("wm8_ack_first", WM, 4'd8, 8'h66, 1, 1, 1, 0, 3);
    snoop("rm8_inval", RM, 4'd8, 8'h66, 0, 0, 0, 0, 2);

    upd(4'd10, 8'h11, ST_M);
    snoop("rm10_tag_miss", RM, 4'd10, 8'h12, 0, 0, 0, 0, 2);
    snoop("rm10_mod", RM, 4'd10, 8'h11, 2, 1, 1, 0, 4);

    upd(4'd11, 8'h05, 2'b11);
    snoop("rm11_st3", RM, 4'd11, 8'h05, 0, 0, 0, 0, 2);

    // Same index in IDLE: update takes the cycle, snoop stalls one cycle.
    upd_valid = 1'b1; upd_index = 4'd4; upd_tag = 8'h55; upd_state = ST_S;
    snoop_valid = 1'b1; snoop_op = RM; snoop_index = 4'd4; snoop_tag = 8'h55;
    #1 chk("conflict:snoop_ready", {31'd0, snoop_ready}, 32'd0);
    chk("conflict:upd_ready", {31'd0, upd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    #1 chk("conflict:snoop_ready_next", {31'd0, snoop_ready}, 32'd1);
    snoop_wait("conflict_rm4", 4'd4, 8'h55, 0, 1, 0, 0, 2);

    // Different indices proceed together.
    upd_valid = 1'b1; upd_index = 4'd6; upd_tag = 8'h09; upd_state = ST_S;
    snoop_valid = 1'b1; snoop_op = RM; snoop_index = 4'd3; snoop_tag = 8'h00;
    #1 chk("parallel:snoop_ready", {31'd0, snoop_ready}, 32'd1);
    chk("parallel:upd_ready", {31'd0, upd_ready}, 32'd1);
    snoop_wait("parallel_rm3", 4'd3, 8'h00, 0, 0, 0, 0, 2);
    snoop("rm6_shared", RM, 4'd6, 8'h09, 0, 1, 0, 0, 2);

    // Reset while in FLUSH.
    upd(4'd9, 8'h77, ST_M);
    snoop_valid = 1'b1; snoop_op = RM; snoop_index = 4'd9; snoop_tag = 8'h77;
    #1 chk("rstflush:snoop_ready", {31'd0, snoop_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    snoop_valid = 1'b0;
    @(negedge clk);
    chk("rstflush:in_flush", {31'd0, flush_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstflush:flush_drop", {31'd0, flush_valid}, 32'd0);
    chk("rstflush:no_resp", {31'd0, resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstflush:no_resp_held", {31'd0, resp_valid | flush_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstflush:no_resp_after", {31'd0, resp_valid}, 32'd0);
    snoop("post_rst_rm9", RM, 4'd9, 8'h77, 0, 0, 0, 0, 2);
    snoop("post_rst_rm2", RM, 4'd2, 8'h33, 0, 0, 0, 0, 2);
    snoop("post_rst_rm6", RM, 4'd6, 8'h09, 0, 0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
